// File: rtl/text_console_pkg.sv
// Shared types and ASCII constants for the character-cell text console.
package text_console_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCROLL
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] PRINT_MIN  = 8'h20;
    localparam logic [7:0] PRINT_MAX  = 8'h7E;

endpackage

// File: rtl/text_ram.sv
// Screen buffer: one write port with its own registered read (for scrolling),
// plus an independent registered read port for the renderer.
module text_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    input  logic [ADDR_W-1:0] baddr,
    output logic [7:0]        bdata
);

    logic [7:0] mem [DEPTH];

    // Storage has no reset; contents are rebuilt by CLEAR after every reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bdata <= 8'h20;
        else        bdata <= mem[baddr];
    end

endmodule

// File: rtl/text_console.sv
// Text console: byte-stream intake, cursor control, clear and scroll sequencing
// over a ROWS x COLS character buffer read by TextEngine.
module text_console
    import text_console_pkg::*;
#(
    parameter int COLS   = 16,
    parameter int ROWS   = 4,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_charValid,
    input  logic [7:0]        i_char,
    output logic              o_charReady,
    input  logic [ADDR_W-1:0] i_charAddress,
    output logic [7:0]        o_charData,
    output logic [ADDR_W-1:0] o_cursorAddress,
    output logic              o_busy
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(ROWS*COLS-1);
    localparam logic [ADDR_W:0] SCR_LAST = (ADDR_W+1)'(ROWS*COLS);
    localparam logic [ADDR_W:0] COPY_N   = (ADDR_W+1)'((ROWS-1)*COLS);
    localparam logic [RW-1:0]   ROW_MAX  = RW'(ROWS-1);
    localparam logic [CW-1:0]   COL_MAX  = CW'(COLS-1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;

    logic              we;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [7:0]        wdata, rdata;

    assign o_charReady     = (state_q == IDLE);
    assign o_busy          = (state_q != IDLE);
    assign o_cursorAddress = {row_q, col_q};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        we      = 1'b0;
        waddr   = {row_q, col_q};
        wdata   = i_char;
        raddr   = cnt_q[ADDR_W-1:0] + ADDR_W'(COLS);
        unique case (state_q)
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q[ADDR_W-1:0];
                wdata = CHAR_SPACE;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            SCROLL: begin
                // Read of source cell cnt+COLS lands one cycle later as the
                // write to destination cnt-1; beyond the copy region, fill blanks.
                we    = (cnt_q != '0);
                waddr = ADDR_W'(cnt_q - 1'b1);
                wdata = (cnt_q <= COPY_N) ? rdata : CHAR_SPACE;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SCR_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = ROW_MAX;
                    col_d   = '0;
                end
            end
            IDLE: begin
                if (i_charValid) begin
                    if (i_char >= PRINT_MIN && i_char <= PRINT_MAX) begin
                        we = 1'b1;
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            if (row_q == ROW_MAX) state_d = SCROLL;
                            else                  row_d   = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else if (i_char == CHAR_LF) begin
                        col_d = '0;
                        if (row_q == ROW_MAX) state_d = SCROLL;
                        else                  row_d   = row_q + 1'b1;
                    end else if (i_char == CHAR_CR) begin
                        col_d = '0;
                    end else if (i_char == CHAR_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - 1'b1;
                            we    = 1'b1;
                            waddr = {row_q, col_q - 1'b1};
                            wdata = CHAR_SPACE;
                        end
                    end else if (i_char == CHAR_FF) begin
                        state_d = CLEAR;
                        row_d   = '0;
                        col_d   = '0;
                    end
                    cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    text_ram #(
        .DEPTH (ROWS*COLS),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata),
        .baddr(i_charAddress),
        .bdata(o_charData)
    );

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: clear, printing, scroll, control codes, reset.
module tb_text_console;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_charValid = 1'b0;
    logic [7:0] i_char = 8'h00;
    logic       o_charReady;
    logic [5:0] i_charAddress = 6'd0;
    logic [7:0] o_charData;
    logic [5:0] o_cursorAddress;
    logic       o_busy;

    int checks = 0;
    int fails  = 0;

    always #5 i_clk = ~i_clk;

    text_console #(.COLS(16), .ROWS(4), .ADDR_W(6)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_charValid    (i_charValid),
        .i_char         (i_char),
        .o_charReady    (o_charReady),
        .i_charAddress  (i_charAddress),
        .o_charData     (o_charData),
        .o_cursorAddress(o_cursorAddress),
        .o_busy         (o_busy)
    );

    // Waits (bounded) for ready, then presents one byte across one rising edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!o_charReady && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_charReady) begin
            checks++; fails++;
            $display("FAIL send_timeout byte=%h ready never rose", b);
        end
        i_charValid = 1'b1;
        i_char      = b;
        @(posedge i_clk); #1;
        i_charValid = 1'b0;
    endtask

    task automatic read_cell(input logic [5:0] a, output logic [7:0] d);
        i_charAddress = a;
        @(posedge i_clk); #1;
        d = o_charData;
    endtask

    // Counts rising edges until ready is high again (bounded).
    task automatic count_not_ready(output int n);
        n = 0;
        while (!o_charReady && n < 300) begin
            @(posedge i_clk); #1;
            n++;
        end
    endtask

    task automatic check_all_space(input string tag);
        logic [7:0] d;
        for (int i = 0; i < 64; i++) begin
            read_cell(i[5:0], d);
            checks++;
            if (d !== 8'h20) begin
                fails++;
                $display("FAIL %s cell=%0d got=%h exp=20", tag, i, d);
            end
        end
    endtask

    task automatic form_feed();
        int n;
        send(8'h0C);
        count_not_ready(n);
    endtask

    task automatic test_reset();
        int n;
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++; if (o_charReady !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", o_charReady); end
        checks++; if (o_charData !== 8'h20) begin fails++; $display("FAIL rst_data got=%h exp=20", o_charData); end
        checks++; if (o_cursorAddress !== 6'd0) begin fails++; $display("FAIL rst_cursor got=%0d exp=0", o_cursorAddress); end
        checks++; if (o_busy !== 1'b1) begin fails++; $display("FAIL rst_busy got=%b exp=1", o_busy); end
        i_rst_n = 1'b1;
        n = 0;
        while (o_busy && n < 300) begin
            @(posedge i_clk); #1;
            n++;
        end
        checks++; if (n != 64) begin fails++; $display("FAIL rst_clear_len got=%0d exp=64", n); end
        checks++; if (o_charReady !== 1'b1) begin fails++; $display("FAIL rst_ready_after got=%b exp=1", o_charReady); end
        check_all_space("rst_clear_cells");
    endtask

    task automatic test_hi();
        logic [7:0] d;
        send(8'h48);
        checks++; if (o_charReady !== 1'b1) begin fails++; $display("FAIL hi_ready got=%b exp=1", o_charReady); end
        send(8'h49);
        checks++; if (o_cursorAddress !== 6'd2) begin fails++; $display("FAIL hi_cursor got=%0d exp=2", o_cursorAddress); end
        read_cell(6'd0, d);
        checks++; if (d !== 8'h48) begin fails++; $display("FAIL hi_cell0 got=%h exp=48", d); end
        i_charAddress = 6'd1;
        #1;
        checks++; if (o_charData !== 8'h48) begin fails++; $display("FAIL hi_latency_old got=%h exp=48", o_charData); end
        @(posedge i_clk); #1;
        checks++; if (o_charData !== 8'h49) begin fails++; $display("FAIL hi_cell1 got=%h exp=49", o_charData); end
    endtask

    task automatic test_scroll();
        int n;
        logic [7:0] d, e;
        form_feed();
        for (int i = 0; i < 64; i++) send(8'h41);
        count_not_ready(n);
        checks++; if (n != 65) begin fails++; $display("FAIL scroll_len got=%0d exp=65", n); end
        checks++; if (o_cursorAddress !== 6'd48) begin fails++; $display("FAIL scroll_cursor got=%0d exp=48", o_cursorAddress); end
        send(8'h42);
        checks++; if (o_cursorAddress !== 6'd49) begin fails++; $display("FAIL scroll_cursor_b got=%0d exp=49", o_cursorAddress); end
        for (int i = 0; i < 64; i++) begin
            e = (i < 48) ? 8'h41 : (i == 48) ? 8'h42 : 8'h20;
            read_cell(i[5:0], d);
            checks++;
            if (d !== e) begin fails++; $display("FAIL scroll_cell=%0d got=%h exp=%h", i, d, e); end
        end
    endtask

    task automatic test_lf_scroll();
        int n;
        form_feed();
        send(8'h5A);
        send(8'h0A); send(8'h0A); send(8'h0A);
        checks++; if (o_cursorAddress !== 6'd48) begin fails++; $display("FAIL lf_cursor got=%0d exp=48", o_cursorAddress); end
        send(8'h0A);
        count_not_ready(n);
        checks++; if (n != 65) begin fails++; $display("FAIL lf_scroll_len got=%0d exp=65", n); end
        checks++; if (o_cursorAddress !== 6'd48) begin fails++; $display("FAIL lf_scroll_cursor got=%0d exp=48", o_cursorAddress); end
    endtask

    task automatic test_bs_cr();
        logic [7:0] d;
        form_feed();
        send(8'h58);
        send(8'h08);
        checks++; if (o_cursorAddress !== 6'd0) begin fails++; $display("FAIL bs_cursor got=%0d exp=0", o_cursorAddress); end
        send(8'h08);
        checks++; if (o_cursorAddress !== 6'd0) begin fails++; $display("FAIL bs_noop_cursor got=%0d exp=0", o_cursorAddress); end
        checks++; if (o_charReady !== 1'b1) begin fails++; $display("FAIL bs_ready got=%b exp=1", o_charReady); end
        read_cell(6'd0, d);
        checks++; if (d !== 8'h20) begin fails++; $display("FAIL bs_cell0 got=%h exp=20", d); end
        send(8'h61); send(8'h62); send(8'h63);
        send(8'h0A);
        checks++; if (o_cursorAddress !== 6'd16) begin fails++; $display("FAIL lf_cursor got=%0d exp=16", o_cursorAddress); end
        send(8'h64); send(8'h65);
        send(8'h0D);
        checks++; if (o_cursorAddress !== 6'd16) begin fails++; $display("FAIL cr_cursor got=%0d exp=16", o_cursorAddress); end
        read_cell(6'd16, d);
        checks++; if (d !== 8'h64) begin fails++; $display("FAIL cr_cell16 got=%h exp=64", d); end
        read_cell(6'd2, d);
        checks++; if (d !== 8'h63) begin fails++; $display("FAIL cr_cell2 got=%h exp=63", d); end
    endtask

    task automatic test_ff_bell();
        int n;
        logic [7:0] d;
        send(8'h0C);
        count_not_ready(n);
        checks++; if (n != 64) begin fails++; $display("FAIL ff_len got=%0d exp=64", n); end
        checks++; if (o_cursorAddress !== 6'd0) begin fails++; $display("FAIL ff_cursor got=%0d exp=0", o_cursorAddress); end
        check_all_space("ff_cells");
        send(8'h51);
        send(8'h07);
        checks++; if (o_cursorAddress !== 6'd1) begin fails++; $display("FAIL bell_cursor got=%0d exp=1", o_cursorAddress); end
        checks++; if (o_charReady !== 1'b1) begin fails++; $display("FAIL bell_ready got=%b exp=1", o_charReady); end
        read_cell(6'd0, d);
        checks++; if (d !== 8'h51) begin fails++; $display("FAIL bell_cell0 got=%h exp=51", d); end
        read_cell(6'd1, d);
        checks++; if (d !== 8'h20) begin fails++; $display("FAIL bell_cell1 got=%h exp=20", d); end
    endtask

    task automatic test_reset_mid_scroll();
        int n;
        form_feed();
        send(8'h0A); send(8'h0A); send(8'h0A);
        for (int i = 0; i < 16; i++) send(8'h4D);
        checks++; if (o_busy !== 1'b1) begin fails++; $display("FAIL mid_in_scroll busy got=%b exp=1", o_busy); end
        repeat (20) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_charReady !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got=%b exp=0", o_charReady); end
        checks++; if (o_charData !== 8'h20) begin fails++; $display("FAIL mid_rst_data got=%h exp=20", o_charData); end
        checks++; if (o_cursorAddress !== 6'd0) begin fails++; $display("FAIL mid_rst_cursor got=%0d exp=0", o_cursorAddress); end
        checks++; if (o_busy !== 1'b1) begin fails++; $display("FAIL mid_rst_busy got=%b exp=1", o_busy); end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        n = 0;
        while (o_busy && n < 300) begin
            @(posedge i_clk); #1;
            n++;
        end
        checks++; if (n != 64) begin fails++; $display("FAIL mid_clear_len got=%0d exp=64", n); end
        checks++; if (o_cursorAddress !== 6'd0) begin fails++; $display("FAIL mid_clear_cursor got=%0d exp=0", o_cursorAddress); end
        check_all_space("mid_clear_cells");
    endtask

    initial begin
        test_reset();
        test_hi();
        test_scroll();
        test_lf_scroll();
        test_bs_cr();
        test_ff_bell();
        test_reset_mid_scroll();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
